// File: rtl/rom_arbiter.sv
// rom_arbiter
// Shares the single asynchronous program ROM between instruction fetch (m0)
// and data load (m1). At most one ROM read is granted per cycle. The ROM word
// is registered and returned to the granted port one cycle later with an
// rvalid strobe. Each granted access is checked for alignment and range.
// Cycles in which both ports request are counted.
//
// Ports:
//   clock, nreset        system clock (rising edge), asynchronous active-low reset
//   m0_req/m0_addr       fetch request and byte address
//   m0_gnt               fetch request accepted this cycle (combinational)
//   m0_rvalid/rdata/err  fetch response, rdata/err qualified by rvalid
//   m1_*                 same set for the data load port
//   rom_address          byte address driven to the ROM (0 when idle)
//   rom_rdata            ROM asynchronous read data
//   conflict_count       saturating count of cycles with both requests high
module rom_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2048,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             m0_req,
    input  logic [WIDTH-1:0] m0_addr,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic [WIDTH-1:0] m1_addr,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             m1_err,
    output logic [WIDTH-1:0] rom_address,
    input  logic [WIDTH-1:0] rom_rdata,
    output logic [CNT_W-1:0] conflict_count
);

    // First word index past the end of the ROM, sized to the word-address field.
    localparam logic [WIDTH-3:0] DEPTH_LIMIT = (WIDTH-2)'(DEPTH);

    // 0 = m0 was granted last, 1 = m1 was granted last.
    logic             last_ptr;
    logic             access_err;
    logic [WIDTH-1:0] resp_data;

    // Round-robin grant: a lone requester always wins; under contention the
    // port that did not win last time is chosen.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (m0_req && m1_req) begin
            m0_gnt = last_ptr;
            m1_gnt = !last_ptr;
        end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
        end
    end

    // The ROM sees the winning address, or 0 on an idle bus.
    always_comb begin
        rom_address = '0;
        if (m0_gnt) begin
            rom_address = m0_addr;
        end else if (m1_gnt) begin
            rom_address = m1_addr;
        end
    end

    // Errored accesses are still granted but return zero instead of ROM data.
    always_comb begin
        access_err = (rom_address[1:0] != 2'b00) ||
                     (rom_address[WIDTH-1:2] >= DEPTH_LIMIT);
        resp_data  = access_err ? '0 : rom_rdata;
    end

    // Response registers, grant pointer and contention counter. rdata/err
    // only change on a grant so they hold their last value between responses.
    // Reset clears rvalid, which also cancels any response still in flight.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            last_ptr       <= 1'b1;
            m0_rvalid      <= 1'b0;
            m0_rdata       <= '0;
            m0_err         <= 1'b0;
            m1_rvalid      <= 1'b0;
            m1_rdata       <= '0;
            m1_err         <= 1'b0;
            conflict_count <= '0;
        end else begin
            m0_rvalid <= m0_gnt;
            m1_rvalid <= m1_gnt;
            if (m0_gnt) begin
                m0_rdata <= resp_data;
                m0_err   <= access_err;
                last_ptr <= 1'b0;
            end
            if (m1_gnt) begin
                m1_rdata <= resp_data;
                m1_err   <= access_err;
                last_ptr <= 1'b1;
            end
            if (m0_req && m1_req && (conflict_count != {CNT_W{1'b1}})) begin
                conflict_count <= conflict_count + CNT_W'(1);
            end
        end
    end

endmodule
